// File: rtl/hazard_scoreboard.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use and
// long-latency scoreboard interlocks, structural limit on outstanding long
// ops, branch flushes and a stall watchdog.
module hazard_scoreboard #(
    parameter int AW         = 5,
    parameter int MAX_LONG   = 2,
    parameter int CNT_W      = 8,
    parameter int BRANCH_FWD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rs1_D,
    input  logic [AW-1:0]     rs2_D,
    input  logic [AW-1:0]     rd_D,
    input  logic [AW-1:0]     rs2_E,
    input  logic [AW-1:0]     rs1_E,
    input  logic [AW-1:0]     rd_E,
    input  logic [AW-1:0]     rd_M,
    input  logic [AW-1:0]     rd_W,
    input  logic              regwrite_E,
    input  logic              regwrite_M,
    input  logic              regwrite_W,
    input  logic              MemtoregE,
    input  logic              MemtoregM,
    input  logic              uses_rs2_E,
    input  logic              long_E,
    input  logic              long_done,
    input  logic [AW-1:0]     long_done_rd,
    input  logic              MemStall,
    input  logic              branch_taken_E,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              StallE,
    output logic              FlushE,
    output logic              StallM,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [1:0]        BranchForwardAE,
    output logic [1:0]        BranchForwardBE,
    output logic [2**AW-1:0]  busy_vec,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              stall_timeout
);

    localparam int               NREGS     = 2**AW;
    localparam logic [2:0]       MAX_L     = 3'(MAX_LONG);
    localparam logic [CNT_W-1:0] MAX_STALL = '1;

    logic [NREGS-1:0] busy_q, busy_d;
    logic [2:0]       out_q, out_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q, timeout_d;
    logic             load_use, sb_hazard, structural, issue;

    // Forwarding selects for the E-stage ALU and the D-stage branch comparator
    always_comb begin
        ForwardAE = 2'b00;
        if (regwrite_M && rd_M != '0 && rd_M == rs1_E)      ForwardAE = 2'b10;
        else if (regwrite_W && rd_W != '0 && rd_W == rs1_E) ForwardAE = 2'b01;

        ForwardBE = 2'b00;
        if (uses_rs2_E) begin
            if (regwrite_M && rd_M != '0 && rd_M == rs2_E)      ForwardBE = 2'b10;
            else if (regwrite_W && rd_W != '0 && rd_W == rs2_E) ForwardBE = 2'b01;
        end

        BranchForwardAE = 2'b00;
        BranchForwardBE = 2'b00;
        if (BRANCH_FWD != 0) begin
            if (regwrite_E && rd_E != '0 && rd_E == rs1_D)      BranchForwardAE = 2'b01;
            else if (regwrite_W && rd_W != '0 && rd_W == rs1_D) BranchForwardAE = 2'b11;
            if (regwrite_E && rd_E != '0 && rd_E == rs2_D)      BranchForwardBE = 2'b01;
            else if (regwrite_W && rd_W != '0 && rd_W == rs2_D) BranchForwardBE = 2'b11;
        end
    end

    // Hazard detection terms
    always_comb begin
        load_use = (MemtoregE && rd_E != '0 && (rd_E == rs1_D || rd_E == rs2_D)) ||
                   (MemtoregM && rd_M != '0 && (rd_M == rs1_D || rd_M == rs2_D));
        sb_hazard = (rs1_D != '0 && busy_q[rs1_D]) ||
                    (rs2_D != '0 && busy_q[rs2_D]) ||
                    (rd_D  != '0 && busy_q[rd_D]);
        structural = long_E && (out_q == MAX_L) && !long_done;
    end

    // Prioritised pipeline controls: MemStall > structural > branch > interlock
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (MemStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (structural) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else if (branch_taken_E) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use || sb_hazard) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // Next-state for scoreboard, outstanding count and watchdog
    always_comb begin
        issue  = long_E && regwrite_E && rd_E != '0 && !StallE && !FlushE;
        busy_d = busy_q;
        if (long_done) busy_d[long_done_rd] = 1'b0;
        // set applied after clear so a same-cycle set/clear of one register keeps it busy
        if (issue)     busy_d[rd_E] = 1'b1;
        busy_d[0] = 1'b0;

        out_d = out_q;
        if (issue && !long_done)                      out_d = out_q + 3'd1;
        else if (!issue && long_done && out_q != '0)  out_d = out_q - 3'd1;

        stall_cnt_d = '0;
        if (StallF) stall_cnt_d = (stall_cnt_q == MAX_STALL) ? stall_cnt_q
                                                             : stall_cnt_q + CNT_W'(1);
        timeout_d = timeout_q || (stall_cnt_d == MAX_STALL);
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            out_q       <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            out_q       <= out_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy_vec      = busy_q;
    assign stall_cnt     = stall_cnt_q;
    assign stall_timeout = timeout_q;

endmodule
